// File: rtl/multiplier_seq_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package multiplier_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // Iteration counter only needs to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/multiplier_seq_negate.sv
// Conditional two's complement negation, used for operand magnitudes and result fix-up.
module cond_negate #(
    parameter int N = 8
) (
    input  logic         neg,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    assign out = neg ? (~in + N'(1)) : in;

endmodule

// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle on operand magnitudes,
// then a single sign fix-up cycle. Result is held until the next accepted request.
module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               a_signed,
    input  logic               b_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a_n, mag_b_n;
    logic [2*WIDTH-1:0]   fix_out;
    logic [WIDTH:0]       sum;

    assign a_neg = a_signed & a[WIDTH-1];
    assign b_neg = b_signed & b[WIDTH-1];

    cond_negate #(.N(WIDTH)) u_abs_a (.neg(a_neg), .in(a), .out(mag_a_n));
    cond_negate #(.N(WIDTH)) u_abs_b (.neg(b_neg), .in(b), .out(mag_b_n));
    cond_negate #(.N(2*WIDTH)) u_fix (.neg(neg), .in(acc), .out(fix_out));

    // Carry out of the partial sum becomes the new MSB after the right shift.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            cnt   <= '0;
            acc   <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= {{WIDTH{1'b0}}, mag_a_n};
                        mag_b <= mag_b_n;
                        neg   <= a_neg ^ b_neg;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= {sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    out   <= fix_out;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench: directed WIDTH=32 cases plus a random WIDTH=8 sweep against an arithmetic model.
module tb_multiplier_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, as32, bs32;
    logic [31:0] a32, b32;
    logic        busy32, done32;
    logic [63:0] out32;
    logic        start8, as8, bs8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] out8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiplier_seq #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start32), .a_signed(as32), .b_signed(bs32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .out(out32)
    );

    multiplier_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .a_signed(as8), .b_signed(bs8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .out(out8)
    );

    // Reference: sign/zero extend to wide integers, multiply, keep low 2*w bits.
    function automatic logic [127:0] ref_mul(input int w, input logic [63:0] a, input logic [63:0] b,
                                             input logic as, input logic bs);
        logic signed [127:0] xa, xb, p;
        logic [127:0] mask;
        xa = 128'(a);
        xb = 128'(b);
        if (as && a[w-1]) xa = xa - (128'(1) << w);
        if (bs && b[w-1]) xb = xb - (128'(1) << w);
        p = xa * xb;
        mask = (128'(1) << (2 * w)) - 128'(1);
        return p & mask;
    endfunction

    // Called at a negedge; returns result, edge count until done seen, and whether out stayed put.
    task automatic run32(input logic [31:0] ia, input logic [31:0] ib, input logic ias, input logic ibs,
                         output logic [63:0] res, output int lat, output bit held);
        logic [63:0] prev;
        prev = out32;
        held = 1'b1;
        a32 = ia; b32 = ib; as32 = ias; bs32 = ibs; start32 = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            start32 = 1'b0;
            if (done32) break;
            if (out32 !== prev) held = 1'b0;
            if (lat > 200) break;
        end
        res = out32;
    endtask

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ias, input logic ibs,
                        output logic [15:0] res, output int lat);
        a8 = ia; b8 = ib; as8 = ias; bs8 = ibs; start8 = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            start8 = 1'b0;
            if (done8 || lat > 100) break;
        end
        res = out8;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start32 = 0; as32 = 0; bs32 = 0; a32 = '0; b32 = '0;
        start8 = 0; as8 = 0; bs8 = 0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || out32 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset32: busy=%b done=%b out=%h, want 0 0 0", busy32, done32, out32);
        end
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || out8 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset8: busy=%b done=%b out=%h, want 0 0 0", busy8, done8, out8);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vas[8];
        logic        vbs[8];
        logic [63:0] vexp[8];
        logic [63:0] res;
        int          lat;
        bit          held;
        va[0] = 32'd3;          vb[0] = 32'd5;          vas[0] = 0; vbs[0] = 0; vexp[0] = 64'h0000_0000_0000_000F;
        va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;  vas[1] = 0; vbs[1] = 0; vexp[1] = 64'hFFFF_FFFE_0000_0001;
        va[2] = 32'hFFFF_FFFE;  vb[2] = 32'd3;          vas[2] = 1; vbs[2] = 1; vexp[2] = 64'hFFFF_FFFF_FFFF_FFFA;
        va[3] = 32'hFFFF_FFFF;  vb[3] = 32'd2;          vas[3] = 1; vbs[3] = 0; vexp[3] = 64'hFFFF_FFFF_FFFF_FFFE;
        va[4] = 32'h8000_0000;  vb[4] = 32'h8000_0000;  vas[4] = 1; vbs[4] = 1; vexp[4] = 64'h4000_0000_0000_0000;
        va[5] = 32'h8000_0000;  vb[5] = 32'h8000_0000;  vas[5] = 0; vbs[5] = 0; vexp[5] = 64'h4000_0000_0000_0000;
        va[6] = 32'h8000_0000;  vb[6] = 32'd1;          vas[6] = 1; vbs[6] = 1; vexp[6] = 64'hFFFF_FFFF_8000_0000;
        va[7] = 32'd0;          vb[7] = 32'h1234_5678;  vas[7] = 1; vbs[7] = 1; vexp[7] = 64'd0;
        for (int i = 0; i < 8; i++) begin
            run32(va[i], vb[i], vas[i], vbs[i], res, lat, held);
            n_checks++;
            if (res !== vexp[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] out: got %h want %h", i, res, vexp[i]);
            end
            n_checks++;
            if (lat != 34) begin
                n_fail++;
                $display("FAIL directed[%0d] latency: got %0d want 34", i, lat);
            end
            @(negedge clk);
            n_checks++;
            if (done32 !== 1'b0 || busy32 !== 1'b0 || out32 !== vexp[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] after done: done=%b busy=%b out=%h want 0 0 %h",
                         i, done32, busy32, out32, vexp[i]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        a32 = 32'd7; b32 = 32'd9; as32 = 0; bs32 = 0; start32 = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start32 = 1'b0;
                n_checks++;
                if (busy32 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_after_accept: got %b want 1", busy32);
                end
            end
            // Disturb operands and pulse start mid-run.
            if (lat == 5) begin a32 = 32'hDEAD_BEEF; b32 = 32'hFFFF_0000; as32 = 1; bs32 = 1; start32 = 1'b1; end
            if (lat == 6) start32 = 1'b0;
            if (done32 || lat > 200) break;
        end
        n_checks++;
        if (out32 !== 64'd63 || lat != 34) begin
            n_fail++;
            $display("FAIL ignore_busy: out=%h lat=%0d want 3f 34", out32, lat);
        end
        start32 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] r1, r2;
        int lat;
        bit held;
        run32(32'h0001_0000, 32'h0000_0100, 0, 0, r1, lat, held);
        n_checks++;
        if (r1 !== 64'h0000_0000_0100_0000) begin
            n_fail++;
            $display("FAIL b2b first: got %h want 0000000001000000", r1);
        end
        // Start issued in the done cycle itself.
        run32(32'hFFFF_FFF9, 32'd6, 1, 1, r2, lat, held);
        n_checks++;
        if (r2 !== 64'hFFFF_FFFF_FFFF_FFD6 || lat != 34) begin
            n_fail++;
            $display("FAIL b2b second: out=%h lat=%0d want ffffffffffffffd6 34", r2, lat);
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL b2b out_held: out changed before done, want held %h", r1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        a32 = 32'd1000; b32 = 32'd1000; as32 = 0; bs32 = 0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy32 !== 1'b0 || out32 !== 64'd0 || done32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b out=%h done=%b want 0 0 0", busy32, out32, done32);
        end
        reset = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 || busy32) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: activity seen after abort, want none");
        end
    endtask

    task automatic test_random8();
        logic [7:0]  ra, rb;
        logic        ras, rbs;
        logic [15:0] res, exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            ras = 1'($urandom);
            rbs = 1'($urandom);
            if (i == 0) begin ra = 8'h80; rb = 8'h80; ras = 1; rbs = 1; end
            if (i == 1) begin ra = 8'hFF; rb = 8'hFF; ras = 0; rbs = 0; end
            if (i == 2) begin ra = 8'h80; rb = 8'h7F; ras = 1; rbs = 0; end
            if (i == 3) begin ra = 8'h00; rb = 8'hFF; ras = 1; rbs = 1; end
            exp = 16'(ref_mul(8, 64'(ra), 64'(rb), ras, rbs));
            run8(ra, rb, ras, rbs, res, lat);
            n_checks++;
            if (res !== exp || lat != 10) begin
                n_fail++;
                $display("FAIL random8[%0d] %h(%b)*%h(%b): out=%h lat=%0d want %h 10",
                         i, ra, ras, rb, rbs, res, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
